// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Instruction-fetch and data-memory handshake bundle for multicycle_ctrl.
//
// Signals:
//   imem_rdata [7:0]  fetched instruction byte            (memory -> ctrl)
//   imem_valid        imem_rdata valid this cycle         (memory -> ctrl)
//   imem_req          instruction fetch request           (ctrl -> memory)
//   dmem_req          data memory request                 (ctrl -> memory)
//   dmem_we           1 write / 0 read, valid w/ dmem_req (ctrl -> memory)
//   dmem_ack          data memory completion              (memory -> ctrl)
//
// Modports:
//   master : controller side
//   slave  : memory side
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;

  modport master (
    input  imem_rdata,
    input  imem_valid,
    input  dmem_ack,
    output imem_req,
    output dmem_req,
    output dmem_we
  );

  modport slave (
    output imem_rdata,
    output imem_valid,
    output dmem_ack,
    input  imem_req,
    input  dmem_req,
    input  dmem_we
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control unit for a 2-register datapath. Fetches 8-bit
// instructions into IR, then sequences DECODE / EXEC / MEM / WB and drives the
// datapath control lines. A HALT instruction parks the FSM until reset.
//
// IR fields: [7:6] opcode (00 LD, 01 ST, 10 ALU, 11 NOP/HALT),
//            [5] register select, [4:2] ALU function.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   mem_if           imem/dmem handshakes (master modport)
//   o_pc_inc         one-cycle pulse: advance PC (coincides with DECODE)
//   o_instr [7:0]    IR contents to datapath
//   o_alucontrol[2:0] ALU function
//   o_WE [1:0]       one-hot register write enable
//   o_RE [1:0]       one-hot register read enable
//   o_ALU_ToMemReg   1: ALU result to dmem_data_in, 0: to register path
//   o_ALUMem_ToReg   1: writeback from dmem_data_out, 0: from ALU
//   o_halted         HALT executed
//   o_mem_err        sticky data-memory timeout error
//
// Parameters:
//   TIMEOUT_CYCLES   data-memory wait limit in MEM cycles
//
// Configuration macro:
//   CTRL_MEM_TIMEOUT_EN  when defined, MEM gives up after TIMEOUT_CYCLES
//                        cycles without dmem_ack, sets o_mem_err and refetches.
//                        When undefined, MEM waits forever and o_mem_err is 0.
//
// All control outputs are registered: they are computed from the next state
// and next IR, so each output is a clean Moore function of the current state.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  multicycle_ctrl_if.master  mem_if,
  output logic               o_pc_inc,
  output logic [7:0]         o_instr,
  output logic [2:0]         o_alucontrol,
  output logic [1:0]         o_WE,
  output logic [1:0]         o_RE,
  output logic               o_ALU_ToMemReg,
  output logic               o_ALUMem_ToReg,
  output logic               o_halted,
  output logic               o_mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       pc_inc;
    logic [2:0] alucontrol;
    logic [1:0] we;
    logic [1:0] re;
    logic       alu_to_mem;
    logic       mem_to_reg;
    logic       dmem_req;
    logic       dmem_we;
    logic       halted;
  } ctrl_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("multicycle_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // Control word for a given state and IR.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [7:0] ir);
    ctrl_t      c;
    logic [1:0] oh;
    c  = '0;
    oh = ir[5] ? 2'b10 : 2'b01;
    case (s)
      S_FETCH:  c.imem_req = 1'b1;
      S_DECODE: c.pc_inc   = 1'b1;
      S_EXEC: begin
        c.re = oh;
        if (ir[7:6] == OP_ALU) begin
          c.alucontrol = ir[4:2];
        end else begin
          // ST: pass the selected register straight through to dmem_data_in
          c.alucontrol = 3'b000;
          c.alu_to_mem = 1'b1;
        end
      end
      S_MEM: begin
        c.dmem_req = 1'b1;
        if (ir[7:6] == OP_ST) begin
          c.dmem_we    = 1'b1;
          c.re         = oh;
          c.alu_to_mem = 1'b1;
        end else begin
          c.dmem_we    = 1'b0;
        end
      end
      S_WB: begin
        c.we = oh;
        if (ir[7:6] == OP_LD) begin
          c.mem_to_reg = 1'b1;
        end else begin
          c.re         = oh;
          c.alucontrol = ir[4:2];
        end
      end
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_ir;
  logic [7:0] w_next_ir;
  ctrl_t      r_ctrl;
  ctrl_t      w_next_ctrl;
  logic [1:0] w_op;

  assign w_op = r_ir[7:6];

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_mem_err;
  logic             w_tmo_hit;

  // The final allowed MEM cycle has passed without an ack.
  assign w_tmo_hit = (r_state == S_MEM) && !mem_if.dmem_ack &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // MEM wait counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if ((r_state == S_MEM) && !mem_if.dmem_ack && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
      r_mem_err <= r_mem_err | w_tmo_hit;
    end
  end

  assign o_mem_err = r_mem_err;
`else
  assign o_mem_err = 1'b0;
`endif

  // Next-state and next-IR logic.
  always_comb begin
    w_next_state = r_state;
    w_next_ir    = r_ir;
    case (r_state)
      S_FETCH: begin
        // Only accept a byte while the request is actually on the bus; this
        // also keeps the reset cycle (request low) from loading IR.
        if (mem_if.imem_valid && r_ctrl.imem_req) begin
          w_next_ir    = mem_if.imem_rdata;
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_LD:   w_next_state = S_MEM;
          OP_ST:   w_next_state = S_EXEC;
          OP_ALU:  w_next_state = S_EXEC;
          default: w_next_state = (r_ir[4:0] == 5'b00000) ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC: begin
        if (w_op == OP_ST) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (mem_if.dmem_ack) begin
          w_next_state = (w_op == OP_ST) ? S_FETCH : S_WB;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_next_state = S_FETCH;
        end
`endif
        else begin
          w_next_state = S_MEM;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  assign w_next_ctrl = ctrl_for(w_next_state, w_next_ir);

  // State, IR and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_ir    <= 8'h00;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ir    <= w_next_ir;
      r_ctrl  <= w_next_ctrl;
    end
  end

  assign mem_if.imem_req  = r_ctrl.imem_req;
  assign mem_if.dmem_req  = r_ctrl.dmem_req;
  assign mem_if.dmem_we   = r_ctrl.dmem_we;
  assign o_pc_inc         = r_ctrl.pc_inc;
  assign o_instr          = r_ir;
  assign o_alucontrol     = r_ctrl.alucontrol;
  assign o_WE             = r_ctrl.we;
  assign o_RE             = r_ctrl.re;
  assign o_ALU_ToMemReg   = r_ctrl.alu_to_mem;
  assign o_ALUMem_ToReg   = r_ctrl.mem_to_reg;
  assign o_halted         = r_ctrl.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario pushes the expected
// per-cycle output snapshot for the instructions it drives into a scoreboard
// queue, then pops one entry per cycle and compares it with the DUT outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       pc_inc;
    logic [7:0] instr;
    logic [2:0] alu;
    logic [1:0] we;
    logic [1:0] re;
    logic       a2m;
    logic       m2r;
    logic       dreq;
    logic       dwe;
    logic       halted;
    logic       mem_err;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pc_inc;
  logic [7:0] instr;
  logic [2:0] alucontrol;
  logic [1:0] we_o;
  logic [1:0] re_o;
  logic       alu_to_mem;
  logic       mem_to_reg;
  logic       halted;
  logic       mem_err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic       exp_mem_err = 1'b0;
  logic [7:0] cur_ir = 8'h00;
  snap_t      sb[$];

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .mem_if         (mem_if),
    .o_pc_inc       (pc_inc),
    .o_instr        (instr),
    .o_alucontrol   (alucontrol),
    .o_WE           (we_o),
    .o_RE           (re_o),
    .o_ALU_ToMemReg (alu_to_mem),
    .o_ALUMem_ToReg (mem_to_reg),
    .o_halted       (halted),
    .o_mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic ireq, input logic pinc, input logic [7:0] ins,
                               input logic [2:0] alu, input logic [1:0] we, input logic [1:0] re,
                               input logic a2m, input logic m2r, input logic dreq,
                               input logic dwe, input logic hlt);
    snap_t s;
    s = {ireq, pinc, ins, alu, we, re, a2m, m2r, dreq, dwe, hlt, exp_mem_err};
    return s;
  endfunction

  function automatic snap_t mk_fetch(input logic [7:0] ins);
    return mk(1'b1, 1'b0, ins, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic snap_t mk_ld_mem(input logic [7:0] ins);
    return mk(1'b0, 1'b0, ins, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic snap_t sample_dut();
    snap_t s;
    s = {mem_if.imem_req, pc_inc, instr, alucontrol, we_o, re_o, alu_to_mem, mem_to_reg,
         mem_if.dmem_req, mem_if.dmem_we, halted, mem_err};
    return s;
  endfunction

  // Expected cycles from DECODE up to the last cycle before the next FETCH.
  task automatic push_instr(input logic [7:0] ir, input int mem_cycles);
    logic [1:0] oh;
    logic [2:0] fn;
    oh = ir[5] ? 2'b10 : 2'b01;
    fn = ir[4:2];
    sb.push_back(mk(1'b0, 1'b1, ir, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    case (ir[7:6])
      2'b00: begin
        repeat (mem_cycles) sb.push_back(mk_ld_mem(ir));
        sb.push_back(mk(1'b0, 1'b0, ir, 3'b000, oh, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      2'b01: begin
        sb.push_back(mk(1'b0, 1'b0, ir, 3'b000, 2'b00, oh, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (mem_cycles)
          sb.push_back(mk(1'b0, 1'b0, ir, 3'b000, 2'b00, oh, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      2'b10: begin
        sb.push_back(mk(1'b0, 1'b0, ir, fn, 2'b00, oh, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(1'b0, 1'b0, ir, fn, oh, oh, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      default: begin
        // NOP / HALT: nothing after DECODE here
      end
    endcase
  endtask

  task automatic test_reset();
    snap_t e, a;
    rst_n = 1'b0;
    mem_if.imem_valid = 1'b0;
    mem_if.imem_rdata = 8'h00;
    mem_if.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_mem_err = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    e = sb.pop_front();
    a = sample_dut();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=%h", a, e);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cur_ir = 8'h00;
  endtask

  task automatic test_alu();
    snap_t e, a;
    int n;
    logic [7:0] ir;
    ir = 8'hAC;
    sb.push_back(mk_fetch(cur_ir));
    push_instr(ir, 0);
    sb.push_back(mk_fetch(ir));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = ir;
      mem_if.dmem_ack = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL alu cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = ir;
  endtask

  task automatic test_ld_wait(input logic [7:0] ir, input int mem_cycles);
    snap_t e, a;
    int n;
    sb.push_back(mk_fetch(cur_ir));
    push_instr(ir, mem_cycles);
    sb.push_back(mk_fetch(ir));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = ir;
      mem_if.dmem_ack = (c == 1 + mem_cycles);
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ld_wait%0d cyc=%0d act=%h exp=%h", mem_cycles, c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = ir;
  endtask

  task automatic test_st_same_cycle_ack();
    snap_t e, a;
    int n;
    logic [7:0] ir;
    ir = 8'h60;
    sb.push_back(mk_fetch(cur_ir));
    push_instr(ir, 1);
    sb.push_back(mk_fetch(ir));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = ir;
      mem_if.dmem_ack = (c == 3);
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL st cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = ir;
  endtask

  // imem_valid and dmem_ack held high throughout: acks outside MEM must be
  // ignored and every FETCH accepts at once.
  task automatic test_back_to_back();
    snap_t e, a;
    int n;
    logic [7:0] prog [4];
    prog = '{8'h94, 8'hC1, 8'h20, 8'h5F};
    foreach (prog[i]) begin
      sb.push_back(mk_fetch(cur_ir));
      push_instr(prog[i], 1);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
        mem_if.imem_valid = 1'b1;
        mem_if.imem_rdata = prog[i];
        mem_if.dmem_ack = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        a = sample_dut();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL b2b ir=%h cyc=%0d act=%h exp=%h", prog[i], c, a, e);
        end
        @(posedge clk);
        #1;
      end
      cur_ir = prog[i];
    end
    sb.push_back(mk_fetch(cur_ir));
    mem_if.imem_valid = 1'b0;
    mem_if.dmem_ack = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    a = sample_dut();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL b2b_tail act=%h exp=%h", a, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    snap_t e, a;
    int n;
    logic [7:0] ir;
    ir = 8'h20;
    sb.push_back(mk_fetch(cur_ir));
    sb.push_back(mk(1'b0, 1'b1, ir, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) sb.push_back(mk_ld_mem(ir));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = ir;
      // reset and ack arrive together on the last MEM cycle: reset wins
      rst_n = (c != n - 1);
      mem_if.dmem_ack = (c == n - 1);
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rst_mid cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    mem_if.dmem_ack = 1'b0;
    exp_mem_err = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    e = sb.pop_front();
    a = sample_dut();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL rst_mid_after act=%h exp=%h", a, e);
    end
    @(posedge clk);
    #1;
    cur_ir = 8'h00;
    // recovery: a NOP runs normally
    sb.push_back(mk_fetch(cur_ir));
    push_instr(8'hC1, 0);
    sb.push_back(mk_fetch(8'hC1));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = 8'hC1;
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rst_mid_recover cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = 8'hC1;
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout();
    snap_t e, a;
    int n;
    logic [7:0] ir;
    ir = 8'h00;
    sb.push_back(mk_fetch(cur_ir));
    sb.push_back(mk(1'b0, 1'b1, ir, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (4) sb.push_back(mk_ld_mem(ir));
    exp_mem_err = 1'b1;
    sb.push_back(mk_fetch(ir));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      mem_if.imem_valid = (c == 0);
      mem_if.imem_rdata = ir;
      mem_if.dmem_ack = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL timeout cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = ir;
  endtask
`endif

  task automatic test_halt();
    snap_t e, a;
    int n;
    sb.push_back(mk_fetch(cur_ir));
    push_instr(8'hC0, 0);
    repeat (20) sb.push_back(mk(1'b0, 1'b0, 8'hC0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      // keep tempting the controller with fetch data and acks while halted
      mem_if.imem_valid = 1'b1;
      mem_if.imem_rdata = (c == 0) ? 8'hC0 : 8'h94;
      mem_if.dmem_ack = (c != 0);
      rst_n = (c != n - 1);
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL halt cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    mem_if.imem_valid = 1'b0;
    mem_if.dmem_ack = 1'b0;
    exp_mem_err = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 8'h00, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk_fetch(8'h00));
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      a = sample_dut();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL halt_reset cyc=%0d act=%h exp=%h", c, a, e);
      end
      @(posedge clk);
      #1;
    end
    cur_ir = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_ld_wait(8'h00, 3);
    test_st_same_cycle_ack();
    test_back_to_back();
`ifndef CTRL_MEM_TIMEOUT_EN
    // MEM must wait well past TIMEOUT_CYCLES when the timeout is compiled out
    test_ld_wait(8'h20, 20);
`endif
    test_reset_mid_op();
`ifdef CTRL_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
